// File: rtl/trace_capture_if.sv
// trace_capture_if: capture, trigger and oldest-first readout signals of trace_capture
interface trace_capture_if #(parameter int WIDTH = 8, parameter int DEPTH = 16);
  localparam int CW = $clog2(DEPTH) + 1;
  logic             arm;
  logic             sample_valid;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] trig_mask;
  logic [WIDTH-1:0] trig_value;
  logic             force_trig;
  logic [2:0]       state;
  logic             triggered;
  logic [CW-1:0]    count;
  logic             rd_start;
  logic             rd_ready;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic [15:0]      rd_stamp;
  logic             rd_last;
  modport master (
    output arm, sample_valid, sample, trig_mask, trig_value, force_trig, rd_start, rd_ready,
    input  state, triggered, count, rd_valid, rd_data, rd_stamp, rd_last
  );
  modport slave (
    input  arm, sample_valid, sample, trig_mask, trig_value, force_trig, rd_start, rd_ready,
    output state, triggered, count, rd_valid, rd_data, rd_stamp, rd_last
  );
endinterface

// File: rtl/trace_capture.sv
// trace_capture: circular trace buffer, stops POST samples after a masked-match trigger, oldest-first readout.
// TRACE_TIMESTAMP_EN adds a 16-bit free-running stamp stored with each sample.
module trace_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int POST  = 4
) (
  input logic             clk,
  input logic             reset_n,
  trace_capture_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {ST_IDLE = 3'd0, ST_ARMED = 3'd1, ST_POST = 3'd2, ST_DONE = 3'd3, ST_READ = 3'd4} state_t;
  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, post_cnt_q, post_cnt_d;
  logic [CW-1:0]    count_q, count_d, remaining_q, remaining_d;
  logic             triggered_q, triggered_d, rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             hit, we, load;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0]      ts_q, ts_d, rd_stamp_q, rd_stamp_d;
  logic [15:0]      stamp_mem [DEPTH];
`endif
  assign hit = bus.sample_valid && (bus.force_trig || ((bus.sample ^ bus.trig_value) & bus.trig_mask) == '0);
  assign we  = bus.sample_valid && !bus.arm && (state_q == ST_ARMED || state_q == ST_POST);
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    triggered_d = triggered_q;
    post_cnt_d  = post_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    rd_data_d   = rd_data_q;
    load        = 1'b0;
    if (bus.arm) begin
      state_d     = ST_ARMED;
      wr_ptr_d    = '0;
      count_d     = '0;
      triggered_d = 1'b0;
      rd_valid_d  = 1'b0;
      rd_last_d   = 1'b0;
    end else begin
      if (we) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = (count_q == CW'(DEPTH)) ? count_q : count_q + 1'b1;
      end
      case (state_q)
        ST_ARMED: if (hit) begin
          triggered_d = 1'b1;
          post_cnt_d  = AW'(POST);
          state_d     = (POST == 0) ? ST_DONE : ST_POST;
        end
        ST_POST: if (bus.sample_valid) begin
          post_cnt_d = post_cnt_q - 1'b1;
          state_d    = (post_cnt_q == AW'(1)) ? ST_DONE : ST_POST;
        end
        ST_DONE: if (bus.rd_start) begin
          // a full buffer has wrapped, so its oldest entry sits at the write pointer
          rd_ptr_d    = (count_q == CW'(DEPTH)) ? wr_ptr_q : '0;
          remaining_d = count_q;
          rd_valid_d  = 1'b1;
          rd_last_d   = count_q == CW'(1);
          load        = 1'b1;
          state_d     = ST_READ;
        end
        ST_READ: if (bus.rd_ready) begin
          if (rd_last_q) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            state_d    = ST_DONE;
          end else begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            rd_last_d   = remaining_d == CW'(1);
            load        = 1'b1;
          end
        end
        default: ;
      endcase
    end
    rd_data_d = load ? mem[rd_ptr_d] : rd_data_d;
  end
`ifdef TRACE_TIMESTAMP_EN
  always_comb begin
    ts_d       = ts_q + 16'd1;
    rd_stamp_d = load ? stamp_mem[rd_ptr_d] : rd_stamp_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ts_q       <= '0;
      rd_stamp_q <= '0;
    end else begin
      ts_q       <= ts_d;
      rd_stamp_q <= rd_stamp_d;
    end
  always_ff @(posedge clk)
    if (we) stamp_mem[wr_ptr_q] <= ts_q;
  assign bus.rd_stamp = rd_stamp_q;
`else
  assign bus.rd_stamp = '0;
`endif
  always_ff @(posedge clk)
    if (we) mem[wr_ptr_q] <= bus.sample;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
      post_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      triggered_q <= triggered_d;
      post_cnt_q  <= post_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_data_q   <= rd_data_d;
    end
  assign bus.state     = state_q;
  assign bus.triggered = triggered_q;
  assign bus.count     = count_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_last   = rd_last_q;
endmodule

// File: doc/trace_capture.md
# trace_capture

Synthesizable on-chip trace buffer for nic8: a generalised successor to the printing simulation monitor. Captures a parametrised-width snapshot of CPU state (PC, registers, IR, control bits, buses), concatenated by the parent, into a circular buffer of configurable depth. Capture stops a fixed number of samples after a masked-match trigger. Readout is oldest-first over a valid/ready port, so traces are recoverable in hardware as well as in simulation.

## Interface
- WIDTH, 8, sample width in bits (nic8 full state is 62).
- DEPTH, 16, buffer entries; power of two, >= 2.
- POST, 4, samples stored after the trigger sample; 0 <= POST < DEPTH.
- clk  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- arm  in  1  start a new capture; highest priority.
- sample_valid  in  1  sample present this cycle (CPU step enable).
- sample  in  WIDTH  snapshot to store.
- trig_mask  in  WIDTH  bits compared for trigger.
- trig_value  in  WIDTH  trigger compare value.
- force_trig  in  1  trigger on this cycle's sample regardless of match.
- state  out  3  IDLE=0, ARMED=1, POST=2, DONE=3, READ=4.
- triggered  out  1  trigger sample has been stored for the current capture.
- count  out  $clog2(DEPTH)+1  valid entries, saturating at DEPTH.
- rd_start  in  1  begin readout (honoured in DONE only).
- rd_ready  in  1  consumer accepts rd_data.
- rd_valid  out  1  rd_data/rd_stamp valid.
- rd_data  out  WIDTH  entry being presented.
- rd_stamp  out  16  timestamp of entry.
- rd_last  out  1  presented entry is the newest.

## Operation
- Trigger condition: sample_valid && (force_trig || ((sample & trig_mask) == (trig_value & trig_mask))). trig_mask=0 triggers on the first valid sample.
- IDLE: no writes. Exit only on arm.
- arm, in any state: next state ARMED. wr_ptr=0, count=0, triggered=0, rd_valid=0. The sample on the arm cycle is not stored.
- ARMED: each sample_valid writes at wr_ptr. wr_ptr increments mod DEPTH; count saturates at DEPTH.
  - On trigger, the sample is stored and triggered=1.
  - Then go to POST with post_cnt=POST, or go directly to DONE if POST==0.
- POST: each sample_valid writes and decrements post_cnt. The write that takes post_cnt to 0 moves to DONE. Trigger inputs are ignored.
- DONE: buffer frozen; sample_valid ignored. rd_start moves to READ.
  - rd_ptr = wr_ptr when count==DEPTH, else 0.
  - remaining = count.
- READ:
  - Output registers hold the entry at rd_ptr.
  - On rd_valid && rd_ready: advance rd_ptr mod DEPTH and decrement remaining.
  - When the accepted entry had rd_last=1: rd_valid=0 and return to DONE. The buffer stays intact, so a repeat rd_start re-reads it.
- rd_last = rd_valid && remaining==1.
- rd_start outside DONE is ignored. arm during READ aborts readout.

## Timing
- Reset values: state=IDLE, triggered=0, count=0, rd_valid=0, rd_data=0, rd_stamp=0, rd_last=0, timestamp counter=0, pointers=0.
- Write latency: a sample presented at edge N is in the buffer after edge N. It is readable no earlier than the DONE state.
- The edge that samples rd_start in DONE loads the oldest entry and sets rd_valid=1 (one-cycle latency).
- Each accepted transfer loads the next entry on the same edge. Sustained throughput is 1 entry/cycle.
- With rd_valid=1 and rd_ready=0, rd_data, rd_stamp and rd_last hold stable.
- State, count and triggered are registered. They reflect a write one cycle after the sampling edge.

## Configuration
- TRACE_TIMESTAMP_EN defined:
  - A 16-bit free-running counter increments every clk edge and wraps at 0xFFFF→0.
  - Its value at the write edge is stored alongside each sample and presented on rd_stamp.
- TRACE_TIMESTAMP_EN undefined: no counter or stamp storage; rd_stamp is tied to 0.

## Test plan
- Mid-capture reset: WIDTH=8, DEPTH=8, POST=2; arm, feed 3 samples, drop reset_n asynchronously → state=0, count=0, rd_valid=0 with no clock edge required.
- Wrap capture:
  - Stimulus: trig_mask=0xFF, trig_value=0x0A; arm; feed 0x01..0x0F one per cycle.
  - Capture: DONE after 0x0C is stored, count=8, later samples ignored.
  - Readout: rd_start with rd_ready=1 yields 0x05..0x0C on consecutive cycles; rd_last with 0x0C only; state returns to 3.
- Short capture:
  - Stimulus: trig_value=0x02; arm; feed 0x01..0x06.
  - Capture: DONE with count=4.
  - Readout: 0x01,0x02,0x03,0x04, then rd_valid=0.
- Force and priority:
  - force_trig with sample 0x33, trig_mask=0xFF, trig_value=0x00 → triggered=1, state=2.
  - arm asserted together with sample_valid in POST → state=1, count=0, sample not stored.
- Backpressure: during readout hold rd_ready=0 for 3 cycles → rd_data unchanged, no entry skipped or duplicated; second rd_start re-reads identical sequence.
- Timestamp:
  - With TRACE_TIMESTAMP_EN: samples written with gaps of 1, 3 and 5 idle cycles show rd_stamp deltas of 2, 4 and 6; a capture spanning 0xFFFF shows wrap to 0x0000.
  - Without TRACE_TIMESTAMP_EN: rd_stamp=0 throughout.
